// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the pipeline stage register: NOP payload, hold levels, stage states.
package pipe_stage_hs_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0000_0001;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] entries_held(stage_state_e s);
    case (s)
      ST_ONE:  entries_held = 2'd1;
      ST_FULL: entries_held = 2'd2;
      default: entries_held = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready/data handshake bundle; master drives valid+data, slave drives ready.
interface pipe_stage_hs_if #(
  parameter int unsigned DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs_en_dff.sv
// Enable-gated register with async active-low reset and synchronous clear to RST_VAL.
module pipe_en_dff #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= RST_VAL;
    else if (clr)  q <= RST_VAL;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// level-compared hold stall and synchronous flush with a saturating drop counter.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned   DW         = 32,
  parameter logic [DW-1:0] NOP_VALUE  = DW'(INST_NOP),
  parameter logic [2:0]    HOLD_LEVEL = HOLD_ID,
  parameter bit            SKID_EN    = 1'b1,
  parameter int unsigned   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       hold_flag_i,
  input  logic             flush_i,
  pipe_stage_hs_if.slave   in_if,
  pipe_stage_hs_if.master  out_if,
  output logic [CNT_W-1:0] drop_cnt_o
);

  logic [1:0]       state_q;
  stage_state_e     state, state_d;
  logic [DW-1:0]    main_q, main_d, skid_q, skid_d;
  logic             main_en, skid_en;
  logic             hold_en, in_ready, accept, take;
  logic [1:0]       n_drop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_d;

  assign state   = stage_state_e'(state_q);
  assign hold_en = (hold_flag_i >= HOLD_LEVEL);

  // Skid mode keeps in_ready purely registered; single-entry mode relies on downstream ready.
  assign in_ready = SKID_EN ? ((state != ST_FULL) && !hold_en)
                            : (((state == ST_EMPTY) || out_if.ready) && !hold_en);
  assign accept   = in_if.valid && in_ready;
  assign take     = (state != ST_EMPTY) && out_if.ready && !hold_en;

  assign in_if.ready  = in_ready;
  assign out_if.valid = (state != ST_EMPTY);
  assign out_if.data  = main_q;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    main_en = 1'b0;
    skid_d  = skid_q;
    skid_en = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_if.data;
          main_en = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_d  = in_if.data;
          main_en = 1'b1;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_if.data;
          skid_en = 1'b1;
        end else if (take) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          main_en = 1'b1;
        end
      end
      ST_FULL: begin
        if (take) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          main_en = 1'b1;
          skid_d  = NOP_VALUE;
          skid_en = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Flush acts through the synchronous clear, so it overrides hold and handshake alike.
  assign n_drop  = entries_held(state) + {1'b0, accept};
  assign cnt_sum = {1'b0, drop_cnt_o} + (CNT_W+1)'(n_drop);
  assign cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  pipe_en_dff #(.W(2), .RST_VAL(ST_EMPTY)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .clr(flush_i), .d(state_d), .q(state_q)
  );

  pipe_en_dff #(.W(DW), .RST_VAL(NOP_VALUE)) u_main (
    .clk(clk), .rst(rst), .en(main_en), .clr(flush_i), .d(main_d), .q(main_q)
  );

  pipe_en_dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (
    .clk(clk), .rst(rst), .en(flush_i), .clr(1'b0), .d(cnt_d), .q(drop_cnt_o)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_en_dff #(.W(DW), .RST_VAL(NOP_VALUE)) u_skid (
        .clk(clk), .rst(rst), .en(skid_en), .clr(flush_i), .d(skid_d), .q(skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid;
      assign skid_q      = NOP_VALUE;
      assign unused_skid = ^{skid_d, skid_en};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed + random checks of pipe_stage_hs (skid and single-entry builds) against a queue model.
module tb_pipe_stage_hs;

  localparam logic [31:0] NOP = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hold_flag;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  drop_a;
  logic [1:0]  drop_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned ca, cb;

  always #5 clk = ~clk;

  pipe_stage_hs_if #(.DW(32)) in_a ();
  pipe_stage_hs_if #(.DW(32)) out_a ();
  pipe_stage_hs_if #(.DW(32)) in_b ();
  pipe_stage_hs_if #(.DW(32)) out_b ();

  assign in_a.valid  = in_valid;
  assign in_a.data   = in_data;
  assign out_a.ready = out_ready;
  assign in_b.valid  = in_valid;
  assign in_b.data   = in_data;
  assign out_b.ready = out_ready;

  pipe_stage_hs #(.DW(32), .SKID_EN(1'b1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag), .flush_i(flush),
    .in_if(in_a), .out_if(out_a), .drop_cnt_o(drop_a)
  );

  pipe_stage_hs #(.DW(32), .SKID_EN(1'b0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag), .flush_i(flush),
    .in_if(in_b), .out_if(out_b), .drop_cnt_o(drop_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stage as a bounded FIFO: capacity 2 with skid, else 1 with pass-through on take.
  task automatic model_dut(input int m, input string nm, input logic rdy, input logic vld,
                           input logic [31:0] dat, input int unsigned cnt);
    logic [31:0] q[$];
    int unsigned c, cmax;
    bit hold_en, e_rdy, acc, take;
    if (m == 0) begin q = qa; c = ca; cmax = 255; end
    else        begin q = qb; c = cb; cmax = 3;   end
    hold_en = (hold_flag >= 3'b011);
    if (m == 0) e_rdy = !hold_en && (q.size() < 2);
    else        e_rdy = !hold_en && (q.size() == 0 || out_ready);
    check({nm, ".in_ready"},  {31'b0, rdy}, {31'b0, e_rdy});
    check({nm, ".out_valid"}, {31'b0, vld}, {31'b0, q.size() != 0});
    check({nm, ".out_data"},  dat, (q.size() != 0) ? q[0] : NOP);
    check({nm, ".drop_cnt"},  cnt, c);
    acc  = in_valid && e_rdy;
    take = (q.size() != 0) && out_ready && !hold_en;
    if (flush) begin
      c = c + q.size() + (acc ? 1 : 0);
      if (c > cmax) c = cmax;
      q.delete();
    end else begin
      if (take) void'(q.pop_front());
      if (acc)  q.push_back(in_data);
    end
    if (m == 0) begin qa = q; ca = c; end
    else        begin qb = q; cb = c; end
  endtask

  task automatic step(input logic [2:0] h, input logic f, input logic v,
                      input logic r, input logic [31:0] d);
    hold_flag = h; flush = f; in_valid = v; out_ready = r; in_data = d;
    #1;
    model_dut(0, "a", in_a.ready, out_a.valid, out_a.data, 32'(drop_a));
    model_dut(1, "b", in_b.ready, out_b.valid, out_b.data, 32'(drop_b));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    hold_flag = 3'b000; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst.a.valid", {31'b0, out_a.valid}, 32'd0);
    check("rst.a.data",  out_a.data, NOP);
    check("rst.a.drop",  32'(drop_a), 32'd0);
    check("rst.a.ready", {31'b0, in_a.ready}, 32'd1);
    check("rst.b.valid", {31'b0, out_b.valid}, 32'd0);
    check("rst.b.data",  out_b.data, NOP);
    check("rst.b.drop",  32'(drop_b), 32'd0);
    qa.delete(); qb.delete(); ca = 0; cb = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; hold_flag = '0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    ca = 0; cb = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_check();

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b1, 1'b1, 32'h90 + 32'(i));
    reset_check();
    step(3'b000, 1'b0, 1'b0, 1'b1, 32'h0);

    // Streaming
    for (int i = 0; i < 16; i++) step(3'b000, 1'b0, 1'b1, 1'b1, 32'hA0 + 32'(i));
    repeat (2) step(3'b000, 1'b0, 1'b0, 1'b1, 32'h0);

    // Backpressure
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hB0);
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hB1);
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hB1);
    step(3'b000, 1'b0, 1'b1, 1'b1, 32'hB1);
    repeat (3) step(3'b000, 1'b0, 1'b0, 1'b1, 32'h0);

    // Hold stall and the level just below it
    step(3'b000, 1'b0, 1'b1, 1'b1, 32'hC0);
    repeat (3) step(3'b011, 1'b0, 1'b1, 1'b1, 32'hC1);
    step(3'b111, 1'b0, 1'b1, 1'b1, 32'hC1);
    repeat (2) step(3'b010, 1'b0, 1'b1, 1'b1, 32'hC1);
    repeat (2) step(3'b000, 1'b0, 1'b0, 1'b1, 32'h0);

    // Flush with full stage plus offered input, then flush under hold
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hD0);
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hD1);
    step(3'b000, 1'b1, 1'b1, 1'b0, 32'hD2);
    step(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step(3'b000, 1'b0, 1'b1, 1'b1, 32'hD3);
    step(3'b000, 1'b1, 1'b1, 1'b1, 32'hD4);
    step(3'b000, 1'b0, 1'b1, 1'b0, 32'hE0);
    step(3'b011, 1'b1, 1'b1, 1'b0, 32'hE1);
    step(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Drop counter saturation on the narrow counter
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 1'b0, 1'b1, 1'b0, 32'hF0 + 32'(i));
      step(3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("sat.b.drop", 32'(drop_b), 32'd3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] h;
      h = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step(h, ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), $urandom);
    end

    for (int i = 0; i < 2; i++) step(3'b000, 1'b0, 1'b1, 1'b0, 32'h55 + 32'(i));
    reset_check();
    step(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
